// File: rtl/tank_pkg.sv
// Shared types and constants for the enemy tank AI.
// Directions match the sprite ROM orientation encoding (1..4).
package tank_pkg;

    typedef enum logic [2:0] {
        UP    = 3'd1,
        RIGHT = 3'd2,
        LEFT  = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        PAUSE  = 2'd2,
        MOVE   = 2'd3
    } ai_state_t;

    localparam logic WANDER = 1'b0;
    localparam logic CHASE  = 1'b1;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction

endpackage

// File: rtl/tank_ai_ctrl_if.sv
// Signal bundle between the tank AI and its surroundings (player, bullet engine, VGA).
// master = the AI block, slave = the environment driving it.
interface tank_ai_ctrl_if;
    logic       enable;
    logic       mode;
    logic [9:0] target_X;
    logic [9:0] target_Y;
    logic       fire_ack;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] tank_X;
    logic [9:0] tank_Y;
    logic [2:0] tank_dir;
    logic       is_tank;
    logic       fire_req;
    logic [1:0] state_dbg;

    modport master (
        input  enable, mode, target_X, target_Y, fire_ack, DrawX, DrawY,
        output tank_X, tank_Y, tank_dir, is_tank, fire_req, state_dbg
    );

    modport slave (
        output enable, mode, target_X, target_Y, fire_ack, DrawX, DrawY,
        input  tank_X, tank_Y, tank_dir, is_tank, fire_req, state_dbg
    );
endinterface

// File: rtl/tank_ai_ctrl_lfsr16.sv
// 16-bit Galois LFSR (taps 16/14/13/11), steps only when advance is high.
// A zero seed would lock up, so it is replaced by 1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        advance,
    output logic [15:0] out
);
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q;
endmodule

// File: rtl/tank_ai_ctrl.sv
// Enemy tank AI: WANDER/CHASE FSM stepping once per synchronised frame tick,
// clamped to the arena, with a fire request held until acked then a cooldown.
module tank_ai_ctrl
    import tank_pkg::*;
#(
    parameter int          X_START       = 100,
    parameter int          Y_START       = 380,
    parameter int          X_MIN         = 0,
    parameter int          X_MAX         = SCREEN_W - 1,
    parameter int          Y_MIN         = 0,
    parameter int          Y_MAX         = SCREEN_H - 1,
    parameter int          SIZE          = 32,
    parameter int          STEP          = 1,
    parameter int          DWELL_FRAMES  = 100,
    parameter int          PAUSE_FRAMES  = 8,
    parameter int          FIRE_COOLDOWN = 60,
    parameter int          ALIGN_TOL     = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           frame_clk,
    tank_ai_ctrl_if.master bus
);
    localparam logic signed [10:0] X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE + 1);
    localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE + 1);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic [10:0]        TOL    = 11'(ALIGN_TOL);
    localparam logic [10:0]        SPAN   = 11'(SIZE - 1);
    localparam logic [15:0]        PAUSE_W = 16'(PAUSE_FRAMES);
    localparam logic [15:0]        DWELL_W = 16'(DWELL_FRAMES);
    localparam logic [15:0]        COOL_W  = 16'(FIRE_COOLDOWN);
    localparam logic [9:0]         X_RST   = 10'(X_START);
    localparam logic [9:0]         Y_RST   = 10'(Y_START);

    logic [2:0]         sync_q, sync_d;   // [0],[1] synchroniser, [2] edge-detect history
    logic               tick_q, tick_d;
    ai_state_t          state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    dir_t               dir_q, dir_d;
    logic [15:0]        dwell_q, dwell_d, pause_q, pause_d, cool_q, cool_d;
    logic               fire_q, fire_d;
    logic [15:0]        lfsr;
    logic               run;
    logic signed [10:0] dx, dy, cand_x, cand_y, clamp_x, clamp_y;
    logic [10:0]        adx, ady;
    logic               blocked, ahead, fire_cond;
    dir_t               chase_dir, new_dir;
    logic               unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .advance (tick_q),
        .out     (lfsr)
    );

    assign unused_lfsr = ^{lfsr[15:8], lfsr[3:2]};

    always_comb begin
        sync_d = {sync_q[1:0], frame_clk};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    assign run = tick_q & bus.enable;

    // Geometry: deltas to the target, candidate step and clamping.
    always_comb begin
        dx  = signed'({1'b0, bus.target_X}) - signed'({1'b0, x_q});
        dy  = signed'({1'b0, bus.target_Y}) - signed'({1'b0, y_q});
        adx = abs11(dx);
        ady = abs11(dy);

        cand_x = signed'({1'b0, x_q});
        cand_y = signed'({1'b0, y_q});
        case (dir_q)
            RIGHT:   cand_x = cand_x + STEP_S;
            LEFT:    cand_x = cand_x - STEP_S;
            DOWN:    cand_y = cand_y + STEP_S;
            UP:      cand_y = cand_y - STEP_S;
            default: ;
        endcase

        clamp_x = cand_x;
        if (cand_x < X_LO)      clamp_x = X_LO;
        else if (cand_x > X_HI) clamp_x = X_HI;
        clamp_y = cand_y;
        if (cand_y < Y_LO)      clamp_y = Y_LO;
        else if (cand_y > Y_HI) clamp_y = Y_HI;
        blocked = (clamp_x != cand_x) || (clamp_y != cand_y);

        // Tie on |dx| == |dy| favours the horizontal axis.
        chase_dir = dir_q;
        if (dx != 11'sd0 || dy != 11'sd0) begin
            if (adx >= ady) chase_dir = dx[10] ? LEFT : RIGHT;
            else            chase_dir = dy[10] ? UP : DOWN;
        end
        new_dir = (bus.mode == CHASE) ? chase_dir : dir_t'({1'b0, lfsr[1:0]} + 3'd1);

        ahead = 1'b0;
        case (dir_q)
            RIGHT:   ahead = !dx[10] && (dx != 11'sd0) && (ady <= TOL);
            LEFT:    ahead =  dx[10] && (ady <= TOL);
            DOWN:    ahead = !dy[10] && (dy != 11'sd0) && (adx <= TOL);
            UP:      ahead =  dy[10] && (adx <= TOL);
            default: ahead = 1'b0;
        endcase
        fire_cond = (bus.mode == CHASE) ? ahead : (lfsr[7:4] == 4'h0);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        pause_d = pause_q;
        cool_d  = cool_q;
        fire_d  = fire_q;

        case (state_q)
            IDLE: begin
                if (run) state_d = DECIDE;
            end
            DECIDE: begin
                if (bus.enable) begin
                    dir_d   = new_dir;
                    dwell_d = 16'd0;
                    pause_d = PAUSE_W;
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (run) begin
                    if (pause_q <= 16'd1) begin
                        pause_d = 16'd0;
                        state_d = MOVE;
                    end else begin
                        pause_d = pause_q - 16'd1;
                    end
                end
            end
            MOVE: begin
                if (run) begin
                    x_d = clamp_x[9:0];
                    y_d = clamp_y[9:0];
                    if (blocked) begin
                        state_d = DECIDE;
                    end else begin
                        dwell_d = dwell_q + 16'd1;
                        if (dwell_q + 16'd1 >= DWELL_W) state_d = DECIDE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An ack always takes priority over a fresh request in the same cycle.
        if (fire_q && bus.fire_ack) begin
            fire_d = 1'b0;
            cool_d = COOL_W;
        end else begin
            if (run && cool_q != 16'd0) cool_d = cool_q - 16'd1;
            if (run && state_q == MOVE && cool_q == 16'd0 && !fire_q && fire_cond) begin
                fire_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q  <= 3'b000;
            tick_q  <= 1'b0;
            state_q <= IDLE;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            dir_q   <= UP;
            dwell_q <= 16'd0;
            pause_q <= 16'd0;
            cool_q  <= 16'd0;
            fire_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            pause_q <= pause_d;
            cool_q  <= cool_d;
            fire_q  <= fire_d;
        end
    end

    always_comb begin
        bus.tank_X    = x_q;
        bus.tank_Y    = y_q;
        bus.tank_dir  = dir_q;
        bus.state_dbg = state_q;
        bus.fire_req  = fire_q;
        bus.is_tank   = ({1'b0, bus.DrawX} >= {1'b0, x_q}) && ({1'b0, bus.DrawX} <= {1'b0, x_q} + SPAN) &&
                        ({1'b0, bus.DrawY} >= {1'b0, y_q}) && ({1'b0, bus.DrawY} <= {1'b0, y_q} + SPAN);
    end
endmodule

// File: tb/tb_tank_ai_ctrl.sv
// Bench for tank_ai_ctrl: two instances (default arena with short pause, and a
// near-wall instance with STEP=4), expected positions queued per frame tick.
module tb_tank_ai_ctrl;
    logic clk;
    logic rst_n;
    logic frame_clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;
    pos_t exp_q[$];

    tank_ai_ctrl_if bus_a();
    tank_ai_ctrl_if bus_b();

    tank_ai_ctrl #(.PAUSE_FRAMES(2)) dut_a (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .bus       (bus_a)
    );

    tank_ai_ctrl #(.X_START(600), .X_MAX(638), .STEP(4), .PAUSE_FRAMES(2)) dut_b (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .bus       (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame_clk period; returns 1 ns after a rising Clk edge.
    task automatic do_tick();
        frame_clk = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        frame_clk = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.tank_X !== 10'd100) begin errors++; $display("FAIL reset_x: got %0d want 100", bus_a.tank_X); end
        checks++; if (bus_a.tank_Y !== 10'd380) begin errors++; $display("FAIL reset_y: got %0d want 380", bus_a.tank_Y); end
        checks++; if (bus_a.tank_dir !== 3'd1) begin errors++; $display("FAIL reset_dir: got %0d want 1", bus_a.tank_dir); end
        checks++; if (bus_a.fire_req !== 1'b0) begin errors++; $display("FAIL reset_fire: got %0b want 0", bus_a.fire_req); end
        checks++; if (bus_a.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus_a.state_dbg); end
        checks++; if (bus_b.tank_X !== 10'd600) begin errors++; $display("FAIL reset_xb: got %0d want 600", bus_b.tank_X); end
    endtask

    task automatic test_is_tank();
        logic [9:0] px  [4] = '{10'd100, 10'd131, 10'd132, 10'd99};
        logic [9:0] py  [4] = '{10'd380, 10'd411, 10'd380, 10'd380};
        logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus_a.DrawX = px[i];
            bus_a.DrawY = py[i];
            #1;
            checks++;
            if (bus_a.is_tank !== exp[i]) begin
                errors++;
                $display("FAIL is_tank(%0d,%0d): got %0b want %0b", px[i], py[i], bus_a.is_tank, exp[i]);
            end
        end
    endtask

    task automatic test_chase_right();
        pos_t got, want;
        bus_a.mode     = 1'b1;
        bus_a.target_X = 10'd300;
        bus_a.target_Y = 10'd380;
        bus_a.enable   = 1'b1;
        do_tick();
        checks++; if (bus_a.state_dbg !== 2'd2) begin errors++; $display("FAIL chase_pause_state: got %0d want 2", bus_a.state_dbg); end
        checks++; if (bus_a.tank_dir !== 3'd2) begin errors++; $display("FAIL chase_dir: got %0d want 2", bus_a.tank_dir); end
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back('{x: (i < 2) ? 10'd100 : 10'(99 + i), y: 10'd380});
            do_tick();
            want = exp_q.pop_front();
            got  = '{x: bus_a.tank_X, y: bus_a.tank_Y};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL chase_pos tick %0d: got (%0d,%0d) want (%0d,%0d)", i, got.x, got.y, want.x, want.y);
            end
        end
        checks++; if (bus_a.state_dbg !== 2'd3) begin errors++; $display("FAIL chase_move_state: got %0d want 3", bus_a.state_dbg); end
    endtask

    task automatic test_enable_drop();
        pos_t got, want;
        bus_a.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{x: 10'd110, y: 10'd380});
            do_tick();
            want = exp_q.pop_front();
            got  = '{x: bus_a.tank_X, y: bus_a.tank_Y};
            checks++;
            if (got !== want || bus_a.state_dbg !== 2'd3) begin
                errors++;
                $display("FAIL enable_hold tick %0d: got (%0d,%0d) st %0d want (%0d,%0d) st 3", i, got.x, got.y, bus_a.state_dbg, want.x, want.y);
            end
        end
        bus_a.enable = 1'b1;
        exp_q.push_back('{x: 10'd111, y: 10'd380});
        do_tick();
        want = exp_q.pop_front();
        checks++;
        if (bus_a.tank_X !== want.x) begin errors++; $display("FAIL enable_resume: got %0d want %0d", bus_a.tank_X, want.x); end
    endtask

    task automatic test_async_reset();
        pos_t want;
        int   mx = 111;
        for (int i = 0; i < 39; i++) begin
            mx++;
            exp_q.push_back('{x: 10'(mx), y: 10'd380});
            do_tick();
            want = exp_q.pop_front();
            checks++;
            if (bus_a.tank_X !== want.x || bus_a.tank_Y !== want.y) begin
                errors++;
                $display("FAIL walk_pos: got (%0d,%0d) want (%0d,%0d)", bus_a.tank_X, bus_a.tank_Y, want.x, want.y);
            end
        end
        checks++; if (bus_a.state_dbg !== 2'd3) begin errors++; $display("FAIL pre_reset_state: got %0d want 3", bus_a.state_dbg); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.tank_X !== 10'd100) begin errors++; $display("FAIL areset_x: got %0d want 100", bus_a.tank_X); end
        checks++; if (bus_a.tank_Y !== 10'd380) begin errors++; $display("FAIL areset_y: got %0d want 380", bus_a.tank_Y); end
        checks++; if (bus_a.tank_dir !== 3'd1) begin errors++; $display("FAIL areset_dir: got %0d want 1", bus_a.tank_dir); end
        checks++; if (bus_a.fire_req !== 1'b0) begin errors++; $display("FAIL areset_fire: got %0b want 0", bus_a.fire_req); end
        checks++; if (bus_a.state_dbg !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d want 0", bus_a.state_dbg); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fire();
        int first_tick = -1;
        bus_a.target_X = 10'd300;
        bus_a.target_Y = 10'd382;
        bus_a.enable   = 1'b1;
        for (int t = 1; t <= 10 && first_tick < 0; t++) begin
            do_tick();
            if (bus_a.fire_req === 1'b1) first_tick = t;
        end
        checks++;
        if (first_tick != 4) begin errors++; $display("FAIL fire_first_tick: got %0d want 4", first_tick); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_a.fire_req !== 1'b1) begin errors++; $display("FAIL fire_hold cycle %0d: got %0b want 1", c, bus_a.fire_req); end
        end
        bus_a.fire_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_a.fire_ack = 1'b0;
        checks++;
        if (bus_a.fire_req !== 1'b0) begin errors++; $display("FAIL fire_ack_clear: got %0b want 0", bus_a.fire_req); end
        for (int t = 1; t <= 60; t++) begin
            if (t == 30) begin
                bus_a.fire_ack = 1'b1;
                @(posedge clk);
                #1;
                bus_a.fire_ack = 1'b0;
            end
            do_tick();
            checks++;
            if (bus_a.fire_req !== 1'b0) begin errors++; $display("FAIL cooldown tick %0d: got %0b want 0", t, bus_a.fire_req); end
        end
        do_tick();
        checks++;
        if (bus_a.fire_req !== 1'b1) begin errors++; $display("FAIL refire: got %0b want 1", bus_a.fire_req); end
    endtask

    task automatic test_wall();
        pos_t       want;
        logic [1:0] st [8];
        logic [9:0] xs [8];
        int         hit = -1;
        bus_b.mode     = 1'b1;
        bus_b.target_X = 10'd639;
        bus_b.target_Y = 10'd380;
        bus_b.enable   = 1'b1;
        do_tick();
        checks++; if (bus_b.tank_dir !== 3'd2) begin errors++; $display("FAIL wall_dir: got %0d want 2", bus_b.tank_dir); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{x: (i < 2) ? 10'd600 : 10'd604, y: 10'd380});
            do_tick();
            want = exp_q.pop_front();
            checks++;
            if (bus_b.tank_X !== want.x) begin errors++; $display("FAIL wall_pos %0d: got %0d want %0d", i, bus_b.tank_X, want.x); end
        end
        frame_clk = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            st[c] = bus_b.state_dbg;
            xs[c] = bus_b.tank_X;
            if (hit < 0 && xs[c] == 10'd607) hit = c;
        end
        frame_clk = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (hit < 0 || hit > 6) begin
            errors++;
            $display("FAIL wall_clamp: x never reached 607 (last %0d)", xs[7]);
        end else if (st[hit] !== 2'd1 || st[hit+1] !== 2'd2) begin
            errors++;
            $display("FAIL wall_states: got %0d,%0d want 1,2", st[hit], st[hit+1]);
        end
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back('{x: 10'd607, y: 10'd380});
            do_tick();
            want = exp_q.pop_front();
            checks++;
            if (bus_b.tank_X !== want.x || bus_b.tank_Y !== want.y) begin
                errors++;
                $display("FAIL wall_stuck %0d: got (%0d,%0d) want (%0d,%0d)", i, bus_b.tank_X, bus_b.tank_Y, want.x, want.y);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        frame_clk      = 1'b0;
        bus_a.enable   = 1'b0;
        bus_a.mode     = 1'b0;
        bus_a.target_X = 10'd0;
        bus_a.target_Y = 10'd0;
        bus_a.fire_ack = 1'b0;
        bus_a.DrawX    = 10'd0;
        bus_a.DrawY    = 10'd0;
        bus_b.enable   = 1'b0;
        bus_b.mode     = 1'b0;
        bus_b.target_X = 10'd0;
        bus_b.target_Y = 10'd0;
        bus_b.fire_ack = 1'b0;
        bus_b.DrawX    = 10'd0;
        bus_b.DrawY    = 10'd0;

        test_reset();
        test_is_tank();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_chase_right();
        test_enable_drop();
        test_async_reset();
        test_fire();
        test_wall();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
